pipe_scoreboard: RTL and testbench

- Parametrised hazard and forwarding controller for the in-order MIPS pipeline.
- Replaces hard-wired EX/MEM/WB compare chains and fixed load-use detection with a shift-register scoreboard of STAGES in-flight destination entries.
- Each entry records which stage its result becomes forwardable in, so multi-cycle memory or ALU latencies need only a parameter and opcode change.
- Sits beside the ID stage. It drives the ID stall, the per-operand forward-source selects, and bubble insertion into EX.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/sb_operand_match.sv | 40 ++++
 rtl/pipe_scoreboard.sv | 114 +++++++++++
 tb/tb_pipe_scoreboard.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/forwarding scoreboard:
// stage-index constants, ready-stage codes, the scoreboard entry record
// and the entry match helper used by the operand search.
package pipe_pkg;

   // Field widths of a scoreboard entry; the top-level REG_W / RS_W
   // parameters are expected to equal these.
   localparam int SB_REG_W = 5;
   localparam int SB_RS_W  = 2;

   // Post-ID stage indices (entry index k of the scoreboard).
   localparam int STG_EX  = 0;
   localparam int STG_MEM = 1;
   localparam int STG_WB  = 2;

   // Stage in which a result first becomes forwardable.
   localparam logic [SB_RS_W-1:0] RDY_ALU  = 2'd0;
   localparam logic [SB_RS_W-1:0] RDY_LOAD = 2'd1;

   // One in-flight destination: valid, destination register, ready stage.
   typedef struct packed {
      logic                v;
      logic [SB_REG_W-1:0] rd;
      logic [SB_RS_W-1:0]  rdy;
   } sb_entry_t;

   // True when an entry holds a live write to a non-zero source register.
   function automatic logic sb_match(input sb_entry_t e, input logic [SB_REG_W-1:0] r);
      return e.v && (e.rd == r) && (r != {SB_REG_W{1'b0}});
   endfunction

endpackage

// File: rtl/sb_operand_match.sv
// Youngest-match priority search for one source operand over the
// scoreboard entries, followed by the ready-stage comparison.
module sb_operand_match
   import pipe_pkg::*;
#(
   parameter int STAGES = 3,
   parameter int IDX_W  = 2
) (
   input  sb_entry_t [STAGES-1:0] i_entries,
   input  logic [SB_REG_W-1:0]    i_src,
   input  logic                   i_use,
   output logic                   o_hit,
   output logic [IDX_W-1:0]       o_idx,
   output logic                   o_not_ready
);

   logic w_found;

   // Scan from EX outward; the first (youngest) match alone decides the result.
   always_comb begin
      w_found     = 1'b0;
      o_hit       = 1'b0;
      o_idx       = {IDX_W{1'b0}};
      o_not_ready = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         if (!w_found && i_use && sb_match(i_entries[k], i_src)) begin
            w_found = 1'b1;
            if (k >= int'(i_entries[k].rdy)) begin
               o_hit = 1'b1;
               o_idx = IDX_W'(k);
            end else begin
               o_not_ready = 1'b1;
            end
         end else begin
            w_found = w_found;
         end
      end
   end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard and forwarding controller for the in-order pipeline.
// A shift register of STAGES entries tracks in-flight destination writes;
// stall and forward selects are combinational from the entries and ID.
// Optional build macro SB_PERF_CNT_EN adds saturating stall/hold counters.
module pipe_scoreboard
   import pipe_pkg::*;
#(
   parameter int STAGES = 3,
   parameter int REG_W  = 5,
   parameter int RS_W   = 2,
   parameter int IDX_W  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wen,
   input  logic [REG_W-1:0] id_rd,
   input  logic [RS_W-1:0]  id_ready,
   input  logic             hold,
   input  logic             flush_ex,
   output logic             stall,
   output logic             fwd_a_hit,
   output logic [IDX_W-1:0] fwd_a_idx,
   output logic             fwd_b_hit,
   output logic [IDX_W-1:0] fwd_b_idx
`ifdef SB_PERF_CNT_EN
   ,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      hold_cnt
`endif
);

   sb_entry_t [STAGES-1:0] r_entries;
   sb_entry_t              w_new_entry;
   logic                   w_a_not_ready;
   logic                   w_b_not_ready;

   sb_operand_match #(.STAGES(STAGES), .IDX_W(IDX_W)) u_match_a (
      .i_entries   (r_entries),
      .i_src       (id_rs),
      .i_use       (id_use_rs),
      .o_hit       (fwd_a_hit),
      .o_idx       (fwd_a_idx),
      .o_not_ready (w_a_not_ready)
   );

   sb_operand_match #(.STAGES(STAGES), .IDX_W(IDX_W)) u_match_b (
      .i_entries   (r_entries),
      .i_src       (id_rt),
      .i_use       (id_use_rt),
      .o_hit       (fwd_b_hit),
      .o_idx       (fwd_b_idx),
      .o_not_ready (w_b_not_ready)
   );

   assign stall = id_valid && (w_a_not_ready || w_b_not_ready);

   // Build the entry entering EX: a real write only when ID issues, else a bubble.
   always_comb begin
      w_new_entry = '0;
      if (id_valid && !stall && id_wen && (id_rd != {REG_W{1'b0}})) begin
         w_new_entry.v   = 1'b1;
         w_new_entry.rd  = id_rd;
         w_new_entry.rdy = id_ready;
      end else begin
         w_new_entry = '0;
      end
   end

   // Advance the scoreboard one stage per cycle unless frozen; the last entry retires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_entries <= '0;
      end else if (!hold) begin
         for (int k = STAGES - 1; k >= 1; k--) begin
            r_entries[k] <= r_entries[k-1];
         end
         if (flush_ex) begin
            r_entries[STG_MEM].v <= 1'b0;
         end
         r_entries[STG_EX] <= w_new_entry;
      end
   end

`ifdef SB_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_hold_cnt;

   // Saturating counts of issued-stall cycles and frozen cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= 32'd0;
         r_hold_cnt  <= 32'd0;
      end else begin
         if (stall && !hold && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (hold && (r_hold_cnt != 32'hFFFF_FFFF)) begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign hold_cnt  = r_hold_cnt;
`else
   // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed, table-driven bench for pipe_scoreboard: one table row per
// cycle with hand-computed expected outputs, plus hold and mid-run
// reset sequences. Counter checks are active with SB_PERF_CNT_EN.
module tb_pipe_scoreboard;

   typedef struct {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       wen;
      logic [4:0] rd;
      logic [1:0] rdy;
      logic       hold;
      logic       flush;
      logic       e_stall;
      logic       e_ah;
      logic [1:0] e_ai;
      logic       e_bh;
      logic [1:0] e_bi;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_use_rs;
   logic       id_use_rt;
   logic       id_wen;
   logic [4:0] id_rd;
   logic [1:0] id_ready;
   logic       hold;
   logic       flush_ex;
   logic       stall;
   logic       fwd_a_hit;
   logic [1:0] fwd_a_idx;
   logic       fwd_b_hit;
   logic [1:0] fwd_b_idx;
`ifdef SB_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] hold_cnt;
`endif

   int n_cmp;
   int n_err;
   int exp_stall_cnt;
   int exp_hold_cnt;
   vec_t tbl[$];

   pipe_scoreboard dut (
      .clk       (clk),
      .reset     (reset),
      .id_valid  (id_valid),
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_use_rs (id_use_rs),
      .id_use_rt (id_use_rt),
      .id_wen    (id_wen),
      .id_rd     (id_rd),
      .id_ready  (id_ready),
      .hold      (hold),
      .flush_ex  (flush_ex),
      .stall     (stall),
      .fwd_a_hit (fwd_a_hit),
      .fwd_a_idx (fwd_a_idx),
      .fwd_b_hit (fwd_b_hit),
      .fwd_b_idx (fwd_b_idx)
`ifdef SB_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .hold_cnt  (hold_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_outs(input vec_t v, input string tag);
      chk({tag, ".stall"}, {31'd0, stall},     {31'd0, v.e_stall});
      chk({tag, ".a_hit"}, {31'd0, fwd_a_hit}, {31'd0, v.e_ah});
      chk({tag, ".a_idx"}, {30'd0, fwd_a_idx}, {30'd0, v.e_ai});
      chk({tag, ".b_hit"}, {31'd0, fwd_b_hit}, {31'd0, v.e_bh});
      chk({tag, ".b_idx"}, {30'd0, fwd_b_idx}, {30'd0, v.e_bi});
   endtask

   // Drive one cycle of inputs, check the combinational outputs, then clock.
   task automatic apply(input vec_t v, input string tag);
      id_valid  = v.valid;
      id_rs     = v.rs;
      id_rt     = v.rt;
      id_use_rs = v.urs;
      id_use_rt = v.urt;
      id_wen    = v.wen;
      id_rd     = v.rd;
      id_ready  = v.rdy;
      hold      = v.hold;
      flush_ex  = v.flush;
      #2;
      check_outs(v, tag);
      @(posedge clk);
      #1;
      if (v.e_stall && !v.hold) exp_stall_cnt++;
      if (v.hold) exp_hold_cnt++;
   endtask

   task automatic check_counters(input string tag);
`ifdef SB_PERF_CNT_EN
      chk({tag, ".stall_cnt"}, stall_cnt, 32'(exp_stall_cnt));
      chk({tag, ".hold_cnt"},  hold_cnt,  32'(exp_hold_cnt));
`else
      if (tag.len() == 0) $display("empty tag");
`endif
   endtask

   initial begin
      vec_t v;
      vec_t idle;
      n_cmp = 0;
      n_err = 0;
      exp_stall_cnt = 0;
      exp_hold_cnt  = 0;

      // valid rs    rt    urs   urt   wen   rd     rdy   hold  flush | stall ah ai bh bi
      idle = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
      tbl.push_back(idle);                                                                                           // 0
      tbl.push_back('{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd8,  2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 1 load $8
      tbl.push_back('{1'b1, 5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0}); // 2 load-use stall
      tbl.push_back('{1'b1, 5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0}); // 3 fwd from MEM
      tbl.push_back('{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd9,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 4 alu $9
      tbl.push_back('{1'b1, 5'd0,  5'd9,  1'b0, 1'b1, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0}); // 5 rt fwd EX
      tbl.push_back('{1'b1, 5'd0,  5'd9,  1'b0, 1'b1, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1}); // 6 MEM
      tbl.push_back('{1'b1, 5'd0,  5'd9,  1'b0, 1'b1, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2}); // 7 WB
      tbl.push_back('{1'b1, 5'd0,  5'd9,  1'b0, 1'b1, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 8 retired
      tbl.push_back('{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 9 w $5
      tbl.push_back('{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd6,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 10 w $6
      tbl.push_back('{1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0}); // 11 w $5, read $5
      tbl.push_back('{1'b1, 5'd5,  5'd6,  1'b1, 1'b1, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1}); // 12 youngest wins
      tbl.push_back('{1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 13 w $0
      tbl.push_back('{1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 14 read $0
      tbl.push_back('{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd3,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 15 w $3
      tbl.push_back('{1'b1, 5'd3,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 16 use_rs=0
      tbl.push_back(idle);                                                                                           // 17
      tbl.push_back('{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd7,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 18 w $7
      tbl.push_back('{1'b1, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0}); // 19 flush $7
      tbl.push_back('{1'b1, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 20 $7 gone
      tbl.push_back('{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 21 load $10
      tbl.push_back('{1'b1, 5'd10, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0}); // 22 stall+flush
      tbl.push_back('{1'b1, 5'd10, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 23 load killed
      tbl.push_back('{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd11, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 24 rdy2 $11
      tbl.push_back('{1'b0, 5'd11, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 25 invalid ID
      tbl.push_back('{1'b1, 5'd11, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0}); // 26 k1 < rdy2
      tbl.push_back('{1'b1, 5'd11, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0}); // 27 fwd WB
      tbl.push_back(idle);                                                                                           // 28
      tbl.push_back('{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd12, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 29 load $12
      tbl.push_back('{1'b1, 5'd0,  5'd12, 1'b0, 1'b1, 1'b1, 5'd13, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0}); // 30 B stall, w $13 blocked
      tbl.push_back('{1'b1, 5'd0,  5'd12, 1'b0, 1'b1, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1}); // 31 B fwd MEM
      tbl.push_back('{1'b1, 5'd13, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}); // 32 no $13

      // Reset and idle inputs
      reset = 1'b1;
      id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      id_wen = 1'b0; id_rd = 5'd0; id_ready = 2'd0; hold = 1'b0; flush_ex = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_outs(idle, "reset");
      check_counters("reset");

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("row%0d", i));
      end
      check_counters("table");

      // Hold with a load in EX and a dependent in ID; flush during hold is ignored.
      apply('{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}, "h_load");
      v = '{1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0};
      apply(v, "h_hold0");
      v.flush = 1'b1;
      apply(v, "h_hold1");
      v.flush = 1'b0;
      apply(v, "h_hold2");
      v.hold = 1'b0;
      apply(v, "h_rel");
      v.e_stall = 1'b0; v.e_ah = 1'b1; v.e_ai = 2'd1;
      apply(v, "h_fwd");
      check_counters("hold");

      // Asynchronous reset in the middle of a load-use stall.
      apply('{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0}, "r_load");
      id_valid = 1'b1; id_rs = 5'd9; id_use_rs = 1'b1; id_wen = 1'b0; id_rd = 5'd0; id_ready = 2'd0;
      #2;
      chk("r_pre.stall", {31'd0, stall}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("r_async.stall", {31'd0, stall}, 32'd0);
      chk("r_async.a_hit", {31'd0, fwd_a_hit}, 32'd0);
      exp_stall_cnt = 0;
      exp_hold_cnt  = 0;
      check_counters("r_async");
      @(posedge clk);
      #1;
      reset = 1'b0;
      #2;
      chk("r_after.stall", {31'd0, stall}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
